// File: rtl/free_list_ctrl_pkg.sv
// Shared widths, lane counts and types for the physical-register free list.
package free_list_ctrl_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int FREE_LANES    = 6;
    localparam int ALLOC_LANES   = 2;
    localparam int STAGE_DEPTH   = 12;
    localparam int DRAIN_WIDTH   = 2;

    localparam int PREG_W = $clog2(NUM_PHYS_REGS);
    localparam int CNT_W  = $clog2(NUM_PHYS_REGS + 1);
    localparam int SCNT_W = $clog2(STAGE_DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SCNT_W-1:0] scnt_t;

    // Pointer advance for circular buffers whose depth need not be a power of two; inc < depth.
    function automatic int wrap_add(input int ptr, input int inc, input int depth);
        int sum;
        sum = ptr + inc;
        return (sum >= depth) ? sum - depth : sum;
    endfunction
endpackage

// File: rtl/free_list_ctrl_if.sv
// Retirement free port and rename allocation port of the free-list controller.
interface free_list_ctrl_if;
    import free_list_ctrl_pkg::*;

    logic [FREE_LANES-1:0]  free_valid;
    preg_t [FREE_LANES-1:0] free_preg;
    logic                   free_ready;
    logic [ALLOC_LANES-1:0] alloc_req;
    logic [ALLOC_LANES-1:0] alloc_grant;
    preg_t [ALLOC_LANES-1:0] alloc_preg;
    cnt_t                   free_count;
    scnt_t                  stage_count;
    logic                   err_overflow;

    modport master (
        output free_valid, free_preg, alloc_req,
        input  free_ready, alloc_grant, alloc_preg, free_count, stage_count, err_overflow
    );

    modport slave (
        input  free_valid, free_preg, alloc_req,
        output free_ready, alloc_grant, alloc_preg, free_count, stage_count, err_overflow
    );
endinterface

// File: rtl/frl_stage_buf.sv
// Compacting staging FIFO: up to LANES sparse writes in, up to RD_W oldest entries out per cycle.
// Latency: a write is visible on rd_data the cycle after it is accepted.
// Backpressure: wr_ready only when a full LANES burst fits by registered count; writes are dropped otherwise.
module frl_stage_buf
    import free_list_ctrl_pkg::*;
#(
    parameter int LANES = FREE_LANES,
    parameter int DEPTH = STAGE_DEPTH,
    parameter int RD_W  = DRAIN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              wr_valid,
    input  preg_t [LANES-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic [$clog2(RD_W+1)-1:0]     rd_num,
    output preg_t [RD_W-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    preg_t mem [DEPTH];
    ptr_t  head;
    ptr_t  tail;
    ptr_t  wr_idx [LANES];
    int    n_wr;

    assign wr_ready = (DEPTH - int'(count)) >= LANES;

    // Each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        n_wr = 0;
        for (int i = 0; i < LANES; i++) begin
            wr_idx[i] = PTR_W'(wrap_add(int'(tail), n_wr, DEPTH));
            if (wr_valid[i]) n_wr = n_wr + 1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < RD_W; j++) begin
            rd_data[j] = mem[PTR_W'(wrap_add(int'(head), j, DEPTH))];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= PTR_W'(wrap_add(int'(head), int'(rd_num), DEPTH));
            if (wr_ready) tail <= PTR_W'(wrap_add(int'(tail), n_wr, DEPTH));
            count <= CW'(int'(count) - int'(rd_num) + (wr_ready ? n_wr : 0));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_ready && wr_valid[i]) mem[wr_idx[i]] <= wr_data[i];
        end
    end
endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: stages retirement frees, drains them into a circular list, grants in-order allocations.
// Latency: freed register reaches the list two cycles after the free; grants are combinational from the registered head.
// Backpressure: free_ready drops when the staging buffer cannot absorb a full burst; grants limited by free_count.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    free_list_ctrl_if.slave       fl_if
);
    localparam int FL_INIT = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int DRN_W   = $clog2(DRAIN_WIDTH + 1);

    preg_t                   fl_mem [NUM_PHYS_REGS];
    logic [PREG_W-1:0]       head;
    logic [PREG_W-1:0]       tail;
    cnt_t                    free_count;
    logic                    err_overflow;

    scnt_t                   stage_count;
    logic                    stage_ready;
    preg_t [DRAIN_WIDTH-1:0] drain_data;
    logic [DRN_W-1:0]        drain_num;

    logic [ALLOC_LANES-1:0]  grant;
    preg_t [ALLOC_LANES-1:0] grant_preg;
    int                      n_grant;
    int                      n_req;
    int                      drain_avail;
    logic                    drain_ovf;

    frl_stage_buf #(
        .LANES (FREE_LANES),
        .DEPTH (STAGE_DEPTH),
        .RD_W  (DRAIN_WIDTH)
    ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (fl_if.free_valid),
        .wr_data  (fl_if.free_preg),
        .wr_ready (stage_ready),
        .rd_num   (drain_num),
        .rd_data  (drain_data),
        .count    (stage_count)
    );

    // A lane needs one list entry for itself plus one per requesting lane below it.
    always_comb begin
        grant      = '0;
        grant_preg = '0;
        n_grant    = 0;
        n_req      = 0;
        for (int i = 0; i < ALLOC_LANES; i++) begin
            if (fl_if.alloc_req[i]) begin
                n_req = n_req + 1;
                if (int'(free_count) >= n_req) begin
                    grant[i]      = 1'b1;
                    grant_preg[i] = fl_mem[PREG_W'(wrap_add(int'(head), n_grant, NUM_PHYS_REGS))];
                    n_grant       = n_grant + 1;
                end
            end
        end
    end

    // More entries than physical registers means something was freed twice; hold the drain off.
    always_comb begin
        drain_avail = (int'(stage_count) < DRAIN_WIDTH) ? int'(stage_count) : DRAIN_WIDTH;
        drain_ovf   = (int'(free_count) - n_grant + drain_avail) > NUM_PHYS_REGS;
        drain_num   = drain_ovf ? '0 : DRN_W'(drain_avail);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= PREG_W'(FL_INIT % NUM_PHYS_REGS);
            free_count   <= CNT_W'(FL_INIT);
            err_overflow <= 1'b0;
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                if (i < FL_INIT) fl_mem[i] <= PREG_W'(i + NUM_ARCH_REGS);
                else             fl_mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < DRAIN_WIDTH; j++) begin
                if (j < int'(drain_num)) begin
                    fl_mem[PREG_W'(wrap_add(int'(tail), j, NUM_PHYS_REGS))] <= drain_data[j];
                end
            end
            head       <= PREG_W'(wrap_add(int'(head), n_grant, NUM_PHYS_REGS));
            tail       <= PREG_W'(wrap_add(int'(tail), int'(drain_num), NUM_PHYS_REGS));
            free_count <= CNT_W'(int'(free_count) - n_grant + int'(drain_num));
            if (drain_ovf) err_overflow <= 1'b1;
        end
    end

    assign fl_if.free_ready   = stage_ready;
    assign fl_if.alloc_grant  = grant;
    assign fl_if.alloc_preg   = grant_preg;
    assign fl_if.free_count   = free_count;
    assign fl_if.stage_count  = stage_count;
    assign fl_if.err_overflow = err_overflow;
endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed vector bench for free_list_ctrl: table-driven phases plus burst, overflow and reset sequences.
module tb_free_list_ctrl;
    import free_list_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    free_list_ctrl_if fif ();

    free_list_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .fl_if (fif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] fv;
        int         pr [6];
        logic [1:0] req;
        logic [1:0] g;
        int         p0;
        int         p1;
        int         fc;
        int         sc;
        logic       rdy;
    } vec_t;

    vec_t tbl_a [$];
    vec_t tbl_c [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] fv, input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5, input logic [1:0] req,
                                input logic [1:0] g, input int p0, input int p1, input int fc,
                                input int sc, input logic rdy);
        vec_t v;
        v.fv = fv;
        v.pr[0] = a0; v.pr[1] = a1; v.pr[2] = a2;
        v.pr[3] = a3; v.pr[4] = a4; v.pr[5] = a5;
        v.req = req; v.g = g; v.p0 = p0; v.p1 = p1;
        v.fc = fc; v.sc = sc; v.rdy = rdy;
        return v;
    endfunction

    function automatic vec_t mkn(input logic [1:0] req, input logic [1:0] g, input int p0,
                                 input int p1, input int fc, input int sc, input logic rdy);
        return mk(6'b0, 0, 0, 0, 0, 0, 0, req, g, p0, p1, fc, sc, rdy);
    endfunction

    task automatic drive(input logic [5:0] fv, input int pr [6], input logic [1:0] req);
        fif.free_valid = fv;
        for (int i = 0; i < 6; i++) fif.free_preg[i] = preg_t'(pr[i]);
        fif.alloc_req = req;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        drive(v.fv, v.pr, v.req);
        @(negedge clk);
        chk({name, " grant"}, 32'(fif.alloc_grant), 32'(v.g));
        chk({name, " preg0"}, 32'(fif.alloc_preg[0]), v.p0);
        chk({name, " preg1"}, 32'(fif.alloc_preg[1]), v.p1);
        chk({name, " free_count"}, 32'(fif.free_count), v.fc);
        chk({name, " stage_count"}, 32'(fif.stage_count), v.sc);
        chk({name, " free_ready"}, 32'(fif.free_ready), 32'(v.rdy));
        chk({name, " err"}, 32'(fif.err_overflow), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int pr [6];
        int exp_sc [14];
        int b;
        int maxsc;
        int sent;
        int budget;
        logic [5:0] fv;

        exp_sc = '{0, 6, 10, 8, 6, 10, 8, 6, 10, 8, 6, 4, 2, 0};
        for (int i = 0; i < 6; i++) pr[i] = 0;
        drive(6'b0, pr, 2'b00);

        // Phase A: drain the reset list, empty-list boundary, sparse free and latency.
        for (int k = 0; k < 16; k++)
            tbl_a.push_back(mkn(2'b11, 2'b11, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k, 0, 1'b1));
        tbl_a.push_back(mkn(2'b11, 2'b00, 0, 0, 0, 0, 1'b1));
        tbl_a.push_back(mk(6'b100101, 7, 0, 9, 0, 0, 40, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1));
        tbl_a.push_back(mkn(2'b11, 2'b00, 0, 0, 0, 3, 1'b1));
        tbl_a.push_back(mkn(2'b11, 2'b11, 7, 9, 2, 1, 1'b1));
        tbl_a.push_back(mkn(2'b01, 2'b01, 40, 0, 1, 0, 1'b1));
        tbl_a.push_back(mkn(2'b10, 2'b00, 0, 0, 0, 0, 1'b1));

        // Phase C: grants and drains in the same cycle at free_count 5, across the list wrap.
        tbl_c.push_back(mk(6'b011111, 50, 51, 52, 53, 54, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1));
        tbl_c.push_back(mk(6'b111111, 55, 56, 57, 58, 59, 60, 2'b00, 2'b00, 0, 0, 0, 5, 1'b1));
        tbl_c.push_back(mkn(2'b01, 2'b01, 50, 0, 2, 9, 1'b0));
        tbl_c.push_back(mkn(2'b00, 2'b00, 0, 0, 3, 7, 1'b0));
        tbl_c.push_back(mkn(2'b11, 2'b11, 51, 52, 5, 5, 1'b1));
        tbl_c.push_back(mkn(2'b11, 2'b11, 53, 54, 5, 3, 1'b1));
        tbl_c.push_back(mkn(2'b11, 2'b11, 55, 56, 5, 1, 1'b1));
        tbl_c.push_back(mkn(2'b11, 2'b11, 57, 58, 4, 0, 1'b1));
        tbl_c.push_back(mkn(2'b11, 2'b11, 59, 60, 2, 0, 1'b1));
        tbl_c.push_back(mkn(2'b11, 2'b00, 0, 0, 0, 0, 1'b1));

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset free_count", 32'(fif.free_count), 32);
        chk("reset stage_count", 32'(fif.stage_count), 0);
        chk("reset free_ready", 32'(fif.free_ready), 1);
        chk("reset err", 32'(fif.err_overflow), 0);
        @(posedge clk);
        #1;

        foreach (tbl_a[i]) apply_vec(tbl_a[i], $sformatf("A%0d", i));

        // Phase B: back-to-back full bursts, held while free_ready is low.
        b = 0;
        maxsc = 0;
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 6; i++) pr[i] = 6 * b + i;
            drive((b < 4) ? 6'h3f : 6'h00, pr, 2'b00);
            @(negedge clk);
            chk($sformatf("B%0d stage_count", t), 32'(fif.stage_count), exp_sc[t]);
            chk($sformatf("B%0d free_ready", t), 32'(fif.free_ready), 32'(exp_sc[t] <= 6));
            chk($sformatf("B%0d free_count", t), 32'(fif.free_count), (t == 0) ? 0 : 2 * (t - 1));
            if (int'(fif.stage_count) > maxsc) maxsc = int'(fif.stage_count);
            if (exp_sc[t] <= 6 && b < 4) b++;
            @(posedge clk);
            #1;
        end
        chk("B max stage_count", maxsc, 10);
        for (int i = 0; i < 6; i++) pr[i] = 0;
        for (int k = 0; k < 12; k++) begin
            drive(6'b0, pr, 2'b11);
            @(negedge clk);
            chk($sformatf("B alloc%0d grant", k), 32'(fif.alloc_grant), 32'd3);
            chk($sformatf("B alloc%0d preg0", k), 32'(fif.alloc_preg[0]), 2 * k);
            chk($sformatf("B alloc%0d preg1", k), 32'(fif.alloc_preg[1]), 2 * k + 1);
            chk($sformatf("B alloc%0d free_count", k), 32'(fif.free_count), 24 - 2 * k);
            @(posedge clk);
            #1;
        end

        foreach (tbl_c[i]) apply_vec(tbl_c[i], $sformatf("C%0d", i));

        // Phase D: double free past a full list, then reset in the middle of a burst.
        drive(6'b0, pr, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("D reset free_count", 32'(fif.free_count), 32);
        chk("D reset stage_count", 32'(fif.stage_count), 0);
        @(posedge clk);
        #1;
        sent = 0;
        budget = 0;
        while (sent < 33 && budget < 200) begin
            fv = (sent + 6 <= 33) ? 6'h3f : 6'((1 << (33 - sent)) - 1);
            for (int i = 0; i < 6; i++) pr[i] = sent + i;
            drive(fv, pr, 2'b00);
            @(negedge clk);
            if (fif.free_ready) sent += $countones(fv);
            @(posedge clk);
            #1;
            budget++;
        end
        for (int i = 0; i < 6; i++) pr[i] = 0;
        drive(6'b0, pr, 2'b00);
        chk("D frees sent", sent, 33);
        budget = 0;
        while (!fif.err_overflow && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        @(negedge clk);
        chk("D err_overflow", 32'(fif.err_overflow), 1);
        chk("D free_count full", 32'(fif.free_count), 64);
        chk("D stuck stage_count", 32'(fif.stage_count), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("D err sticky", 32'(fif.err_overflow), 1);
        chk("D free_count held", 32'(fif.free_count), 64);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) pr[i] = 10 + i;
        drive(6'h3f, pr, 2'b01);
        #2 rst = 1'b0;
        #1;
        chk("R free_count", 32'(fif.free_count), 32);
        chk("R stage_count", 32'(fif.stage_count), 0);
        chk("R err", 32'(fif.err_overflow), 0);
        chk("R grant", 32'(fif.alloc_grant), 1);
        chk("R preg0", 32'(fif.alloc_preg[0]), 32);
        @(posedge clk);
        #1;
        chk("R held stage_count", 32'(fif.stage_count), 0);
        chk("R held free_count", 32'(fif.free_count), 32);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
